// File: rtl/riscv_div_arbiter.sv
// Round-robin front end that shares one serial integer divider between NUM_REQ requesters:
// latches the winner's operands, prepares the normalised divisor and returns the result to its owner.
module riscv_div_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic [NUM_REQ-1:0]         ReqVld_SI,
  input  logic [NUM_REQ*C_WIDTH-1:0] ReqOpA_DI,
  input  logic [NUM_REQ*C_WIDTH-1:0] ReqOpB_DI,
  input  logic [NUM_REQ*2-1:0]       ReqOpCode_SI,
  output logic [NUM_REQ-1:0]         ReqGnt_SO,
  output logic [NUM_REQ-1:0]         RespVld_SO,
  input  logic [NUM_REQ-1:0]         RespRdy_SI,
  output logic [C_WIDTH-1:0]         Res_DO,
  output logic [C_WIDTH-1:0]         DivOpA_DO,
  output logic [C_WIDTH-1:0]         DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0]     DivOpBShift_DO,
  output logic                       DivOpBIsZero_SO,
  output logic                       DivOpBSign_SO,
  output logic [1:0]                 DivOpCode_SO,
  output logic                       DivInVld_SO,
  input  logic                       DivOutVld_SI,
  output logic                       DivOutRdy_SO,
  input  logic [C_WIDTH-1:0]         DivRes_DI
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDW-1:0]           r_rr_ptr;
  logic [IDW-1:0]           r_id;
  logic [IDW-1:0]           w_win_id;
  logic [IDW-1:0]           w_ptr_nxt;
  logic                     w_win_found;
  logic [NUM_REQ-1:0]       w_win_onehot;
  logic [NUM_REQ-1:0]       w_id_onehot;
  logic                     w_resp_hs;
  logic [C_WIDTH-1:0]       r_opa;
  logic [C_WIDTH-1:0]       r_opb;
  logic [C_WIDTH-1:0]       r_res;
  logic [1:0]               r_opcode;
  logic [C_LOG_WIDTH-1:0]   w_shift;

  // Normalisation shift: leading zeros for unsigned ops, redundant sign bits for signed ops.
  function automatic logic [C_LOG_WIDTH-1:0] f_norm_shift(input logic [C_WIDTH-1:0] b,
                                                          input logic is_signed);
    logic [C_WIDTH-1:0]     x;
    logic [C_LOG_WIDTH-1:0] cnt;
    logic                   hit;
    x   = is_signed ? (b ^ {C_WIDTH{b[C_WIDTH-1]}}) : b;
    cnt = '0;
    hit = 1'b0;
    for (int i = C_WIDTH-1; i >= 0; i--) begin
      hit = hit | x[i];
      cnt = cnt + (hit ? C_LOG_WIDTH'(0) : C_LOG_WIDTH'(1));
    end
    if (b == '0) begin
      f_norm_shift = C_LOG_WIDTH'(C_WIDTH-1);
    end else if (is_signed) begin
      f_norm_shift = cnt - C_LOG_WIDTH'(1);
    end else begin
      f_norm_shift = cnt;
    end
  endfunction

  // First asserted request at or after ptr, wrapping; returns {found, id}.
  function automatic logic [IDW:0] f_rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [IDW-1:0] ptr);
    logic [2*NUM_REQ-1:0] rot;
    logic                 hit;
    logic [IDW-1:0]       id;
    rot = {vld, vld} >> ptr;
    hit = 1'b0;
    id  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      id  = rot[k] ? IDW'((int'(ptr) + k) % NUM_REQ) : id;
      hit = hit | rot[k];
    end
    return {hit, id};
  endfunction

  assign {w_win_found, w_win_id} = f_rr_pick(ReqVld_SI, r_rr_ptr);
  assign w_win_onehot = NUM_REQ'(1) << w_win_id;
  assign w_id_onehot  = NUM_REQ'(1) << r_id;
  assign w_resp_hs    = |(RespRdy_SI & w_id_onehot);
  assign w_ptr_nxt    = (int'(r_id) == NUM_REQ-1) ? '0 : r_id + IDW'(1);

  assign w_shift         = f_norm_shift(r_opb, r_opcode[0]);
  assign DivOpA_DO       = r_opa;
  assign DivOpB_DO       = r_opb << w_shift;
  assign DivOpBShift_DO  = w_shift;
  assign DivOpBIsZero_SO = (r_opb == '0);
  assign DivOpBSign_SO   = r_opb[C_WIDTH-1] & r_opcode[0];
  assign DivOpCode_SO    = r_opcode;
  assign Res_DO          = r_res;

  // State register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake strobes; the divider's valid only matters while waiting.
  always_comb begin
    w_state_nxt  = r_state;
    ReqGnt_SO    = '0;
    RespVld_SO   = '0;
    DivInVld_SO  = 1'b0;
    DivOutRdy_SO = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          ReqGnt_SO   = w_win_onehot;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        DivInVld_SO = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (DivOutVld_SI) begin
          DivOutRdy_SO = 1'b1;
          w_state_nxt  = S_RESP;
        end else begin
          w_state_nxt  = S_WAIT;
        end
      end
      S_RESP: begin
        RespVld_SO = w_id_onehot;
        if (w_resp_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on grant, result capture from the divider, pointer advance after delivery.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_opcode <= 2'b00;
      r_id     <= '0;
      r_res    <= '0;
      r_rr_ptr <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_win_found) begin
        r_opa    <= ReqOpA_DI[w_win_id*C_WIDTH +: C_WIDTH];
        r_opb    <= ReqOpB_DI[w_win_id*C_WIDTH +: C_WIDTH];
        r_opcode <= ReqOpCode_SI[w_win_id*2 +: 2];
        r_id     <= w_win_id;
      end
      if ((r_state == S_WAIT) && DivOutVld_SI) begin
        r_res <= DivRes_DI;
      end
      if ((r_state == S_RESP) && w_resp_hs) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_riscv_div_arbiter.sv
// Directed bench for riscv_div_arbiter: transaction-level reference model checked every cycle,
// a behavioural serial divider, and literal expectations for the hand-worked cases.
module tb_riscv_div_arbiter;

  localparam int N = 2;

  logic            Clk_CI = 1'b0;
  logic            Rst_RBI = 1'b0;
  logic [N-1:0]    ReqVld_SI = '0;
  logic [N*32-1:0] ReqOpA_DI = '0;
  logic [N*32-1:0] ReqOpB_DI = '0;
  logic [N*2-1:0]  ReqOpCode_SI = '0;
  logic [N-1:0]    ReqGnt_SO;
  logic [N-1:0]    RespVld_SO;
  logic [N-1:0]    RespRdy_SI = '0;
  logic [31:0]     Res_DO;
  logic [31:0]     DivOpA_DO;
  logic [31:0]     DivOpB_DO;
  logic [5:0]      DivOpBShift_DO;
  logic            DivOpBIsZero_SO;
  logic            DivOpBSign_SO;
  logic [1:0]      DivOpCode_SO;
  logic            DivInVld_SO;
  logic            DivOutVld_SI;
  logic            DivOutRdy_SO;
  logic [31:0]     DivRes_DI;

  riscv_div_arbiter #(.NUM_REQ(N), .C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
    .ReqVld_SI(ReqVld_SI), .ReqOpA_DI(ReqOpA_DI), .ReqOpB_DI(ReqOpB_DI),
    .ReqOpCode_SI(ReqOpCode_SI), .ReqGnt_SO(ReqGnt_SO),
    .RespVld_SO(RespVld_SO), .RespRdy_SI(RespRdy_SI), .Res_DO(Res_DO),
    .DivOpA_DO(DivOpA_DO), .DivOpB_DO(DivOpB_DO), .DivOpBShift_DO(DivOpBShift_DO),
    .DivOpBIsZero_SO(DivOpBIsZero_SO), .DivOpBSign_SO(DivOpBSign_SO),
    .DivOpCode_SO(DivOpCode_SO), .DivInVld_SO(DivInVld_SO),
    .DivOutVld_SI(DivOutVld_SI), .DivOutRdy_SO(DivOutRdy_SO), .DivRes_DI(DivRes_DI)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } op_t;

  op_t q0[$];
  op_t q1[$];
  int  glog[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  always @(posedge Clk_CI) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arithmetic reference for all four ops including the divide-by-zero and overflow cases.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0: return a / b;
      2'd2: return a % b;
      default: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == 2'd1) ? a : 32'd0;
        else if (op == 2'd1) return sa / sb;
        else return sa % sb;
      end
    endcase
  endfunction

  // Largest left shift that keeps B recoverable (logically or arithmetically).
  function automatic int ref_shift(input logic [31:0] b, input logic sgn);
    logic [31:0] t;
    if (b == 32'd0) return 31;
    for (int k = 31; k >= 0; k--) begin
      t = b << k;
      if (sgn) begin
        if (($signed(t) >>> k) == $signed(b)) return k;
      end else begin
        if ((t >> k) == b) return k;
      end
    end
    return 0;
  endfunction

  // Serial divider: busy for shift+1 cycles after a start, valid while idle.
  int          dcnt;
  logic [31:0] dres;
  logic [31:0] brec;
  assign brec = DivOpCode_SO[0] ? 32'($signed(DivOpB_DO) >>> DivOpBShift_DO)
                                : (DivOpB_DO >> DivOpBShift_DO);
  always @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      dcnt <= 0;
      dres <= 32'd0;
    end else if (DivInVld_SO) begin
      dcnt <= int'(DivOpBShift_DO) + 1;
      dres <= ref_div(DivOpA_DO, brec, DivOpCode_SO);
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign DivOutVld_SI = (dcnt == 0);
  assign DivRes_DI    = dres;

  // Requesters: hold the head of their queue until granted, then move on.
  initial begin
    logic [N-1:0] g;
    op_t          tmp;
    forever begin
      @(negedge Clk_CI);
      g = ReqGnt_SO;
      if (g[0]) glog.push_back(0);
      if (g[1]) glog.push_back(1);
      @(posedge Clk_CI);
      #1;
      if (g[0] && q0.size() > 0) tmp = q0.pop_front();
      if (g[1] && q1.size() > 0) tmp = q1.pop_front();
      ReqVld_SI[0] = (q0.size() > 0);
      ReqVld_SI[1] = (q1.size() > 0);
      if (q0.size() > 0) begin
        ReqOpA_DI[31:0] = q0[0].a; ReqOpB_DI[31:0] = q0[0].b; ReqOpCode_SI[1:0] = q0[0].op;
      end
      if (q1.size() > 0) begin
        ReqOpA_DI[63:32] = q1[0].a; ReqOpB_DI[63:32] = q1[0].b; ReqOpCode_SI[3:2] = q1[0].op;
      end
    end
  end

  // Transaction-level reference: one owner at a time, response due s+4 cycles after grant.
  int          m_owner = -1;
  int          m_ptr = 0;
  int          m_gnt_cyc = 0;
  int          m_resp_cyc = 0;
  int          m_s = 0;
  logic [31:0] m_a, m_b, m_res;
  logic [1:0]  m_op;
  int          c_win;
  logic [N-1:0] c_eg, c_erv;

  initial begin
    forever begin
      @(negedge Clk_CI);
      if (!Rst_RBI) begin
        m_owner = -1;
        m_ptr   = 0;
      end else begin
        c_win = -1;
        c_eg  = '0;
        c_erv = '0;
        if (m_owner < 0) begin
          for (int k = 0; k < N; k++) begin
            if (c_win < 0 && ReqVld_SI[(m_ptr + k) % N]) c_win = (m_ptr + k) % N;
          end
          if (c_win >= 0) c_eg[c_win] = 1'b1;
        end
        chk("grant", ReqGnt_SO, c_eg);
        if (m_owner >= 0 && cyc >= m_resp_cyc) c_erv[m_owner] = 1'b1;
        chk("resp_vld", RespVld_SO, c_erv);
        if (c_erv != '0) chk("res", Res_DO, m_res);
        chk("div_in_vld", DivInVld_SO, (m_owner >= 0 && cyc == m_gnt_cyc + 1));
        chk("div_out_rdy", DivOutRdy_SO, (m_owner >= 0 && cyc == m_resp_cyc - 1));
        if (m_owner >= 0 && cyc > m_gnt_cyc) begin
          chk("m_opa", DivOpA_DO, m_a);
          chk("m_opb", DivOpB_DO, m_b << m_s);
          chk("m_shift", DivOpBShift_DO, m_s);
          chk("m_bzero", DivOpBIsZero_SO, (m_b == 32'd0));
          chk("m_bsign", DivOpBSign_SO, m_b[31] & m_op[0]);
          chk("m_opcode", DivOpCode_SO, m_op);
        end
        if (c_win >= 0) begin
          m_owner    = c_win;
          m_gnt_cyc  = cyc;
          m_a        = ReqOpA_DI[c_win*32 +: 32];
          m_b        = ReqOpB_DI[c_win*32 +: 32];
          m_op       = ReqOpCode_SI[c_win*2 +: 2];
          m_s        = ref_shift(m_b, m_op[0]);
          m_resp_cyc = cyc + m_s + 4;
          m_res      = ref_div(m_a, m_b, m_op);
        end else if (c_erv != '0 && RespRdy_SI[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
  end

  task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    op_t t;
    t.a = a; t.b = b; t.op = op;
    if (i == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  task automatic wait_gnt(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk_CI);
      if (ReqGnt_SO[i]) begin ok = 1'b1; break; end
    end
    chk("grant_seen", ok, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge Clk_CI);
      if (q0.size() == 0 && q1.size() == 0 && m_owner < 0 && ReqVld_SI == '0) begin
        ok = 1'b1; break;
      end
    end
    chk("idle_reached", ok, 1'b1);
  endtask

  task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_res,
                         input int exp_s, input logic [31:0] exp_opb);
    bit ok;
    int gc;
    push_op(i, a, b, op);
    wait_gnt(i, ok);
    if (!ok) return;
    gc = cyc;
    @(negedge Clk_CI);
    chk("lit_shift", DivOpBShift_DO, exp_s);
    chk("lit_opb", DivOpB_DO, exp_opb);
    chk("lit_bzero", DivOpBIsZero_SO, (b == 32'd0));
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk_CI);
      if (RespVld_SO[i]) begin ok = 1'b1; break; end
    end
    chk("resp_seen", ok, 1'b1);
    if (!ok) return;
    chk("lit_latency", cyc - gc, exp_s + 4);
    chk("lit_res", Res_DO, exp_res);
    @(negedge Clk_CI);
  endtask

  initial begin
    bit ok;
    int hs;
    RespRdy_SI = 2'b11;
    repeat (2) @(negedge Clk_CI);
    chk("rst_gnt", ReqGnt_SO, 2'b00);
    chk("rst_resp_vld", RespVld_SO, 2'b00);
    chk("rst_div_in", DivInVld_SO, 1'b0);
    chk("rst_div_rdy", DivOutRdy_SO, 1'b0);
    chk("rst_res", Res_DO, 32'd0);
    chk("rst_opa", DivOpA_DO, 32'd0);
    #2 Rst_RBI = 1'b1;

    run_one(0, 32'd100, 32'd7, 2'd0, 32'd14, 29, 32'hE000_0000);
    run_one(0, 32'd100, 32'd7, 2'd2, 32'd2, 29, 32'hE000_0000);
    run_one(1, 32'hFFFF_FFF9, 32'd2, 2'd1, 32'hFFFF_FFFD, 29, 32'h4000_0000);
    run_one(1, 32'hFFFF_FFF9, 32'd2, 2'd3, 32'hFFFF_FFFF, 29, 32'h4000_0000);
    run_one(0, 32'd5, 32'd0, 2'd0, 32'hFFFF_FFFF, 31, 32'd0);
    run_one(0, 32'd5, 32'd0, 2'd2, 32'd5, 31, 32'd0);
    run_one(1, 32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 32'h8000_0000, 31, 32'h8000_0000);
    run_one(1, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 32'd0, 31, 32'h8000_0000);

    // Both requesters held high with the pointer at 0.
    glog.delete();
    push_op(0, 32'd100, 32'd7, 2'd0);
    push_op(0, 32'd50, 32'd5, 2'd0);
    push_op(1, 32'hFFFF_FFF9, 32'd2, 2'd1);
    push_op(1, 32'd9, 32'd3, 2'd0);
    wait_idle();
    chk("alt_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("alt_g0", glog[0], 0);
      chk("alt_g1", glog[1], 1);
      chk("alt_g2", glog[2], 0);
      chk("alt_g3", glog[3], 1);
    end

    // Owner stalls its ready; the other requester's ready must not complete the response.
    RespRdy_SI = 2'b10;
    push_op(0, 32'd100, 32'd7, 2'd0);
    wait_gnt(0, ok);
    push_op(1, 32'd9, 32'd3, 2'd0);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk_CI);
      if (RespVld_SO[0]) begin ok = 1'b1; break; end
    end
    chk("stall_resp_seen", ok, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk_CI);
      chk("stall_vld", RespVld_SO, 2'b01);
      chk("stall_res", Res_DO, 32'd14);
      chk("stall_gnt", ReqGnt_SO, 2'b00);
    end
    @(posedge Clk_CI);
    #1 RespRdy_SI = 2'b11;
    hs = cyc;
    @(negedge Clk_CI);
    @(negedge Clk_CI);
    chk("pending_gnt", ReqGnt_SO, 2'b10);
    chk("pending_gnt_cycle", cyc, hs + 1);
    wait_idle();

    // Reset while the divider is busy.
    push_op(0, 32'd100, 32'd7, 2'd0);
    wait_gnt(0, ok);
    repeat (3) @(negedge Clk_CI);
    #1 Rst_RBI = 1'b0;
    #1;
    chk("mid_rst_vld", RespVld_SO, 2'b00);
    chk("mid_rst_gnt", ReqGnt_SO, 2'b00);
    chk("mid_rst_div_in", DivInVld_SO, 1'b0);
    chk("mid_rst_div_rdy", DivOutRdy_SO, 1'b0);
    chk("mid_rst_res", Res_DO, 32'd0);
    chk("mid_rst_opa", DivOpA_DO, 32'd0);
    chk("mid_rst_bzero", DivOpBIsZero_SO, 1'b1);
    repeat (2) @(negedge Clk_CI);
    #2 Rst_RBI = 1'b1;
    repeat (40) @(negedge Clk_CI);
    run_one(0, 32'd1000, 32'd10, 2'd0, 32'd100, 28, 32'hA000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_div_arbiter.md
Name: riscv_div_arbiter

Overview:
- Shares one serial integer divider (udiv/div/urem/rem, int32) between NUM_REQ requesters, such as the EX stages of several cores or a core plus an accelerator.
- Arbitrates between requesters round-robin and registers the winning operands.
- Computes the divider's operand-preparation inputs (pre-shifted B, shift count, B-is-zero flag, gated B sign).
- Sequences the divider handshake and returns the result to the owning requester with a valid/ready handshake.

Parameters:
- NUM_REQ, 2, number of requesters (≥1); ID width is IDW = max(1, $clog2(NUM_REQ)).
- C_WIDTH, 32, operand and result width.
- C_LOG_WIDTH, 6, width of the shift count; equals $clog2(C_WIDTH+1).

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  asynchronous, active-low reset.
- ReqVld_SI  in  NUM_REQ  per-requester request valid.
- ReqOpA_DI  in  NUM_REQ*C_WIDTH  dividend; requester i uses slice i.
- ReqOpB_DI  in  NUM_REQ*C_WIDTH  divisor.
- ReqOpCode_SI  in  NUM_REQ*2  opcode: 0 udiv, 1 div, 2 urem, 3 rem.
- ReqGnt_SO  out  NUM_REQ  one-hot accept pulse.
- RespVld_SO  out  NUM_REQ  one-hot result valid.
- RespRdy_SI  in  NUM_REQ  per-requester result ready.
- Res_DO  out  C_WIDTH  result, shared by all requesters.
- DivOpA_DO  out  C_WIDTH  dividend to the divider.
- DivOpB_DO  out  C_WIDTH  B shifted left by DivOpBShift_DO.
- DivOpBShift_DO  out  C_LOG_WIDTH  divider iteration count minus 1.
- DivOpBIsZero_SO  out  1  B == 0.
- DivOpBSign_SO  out  1  B[MSB] & OpCode[0].
- DivOpCode_SO  out  2  latched opcode.
- DivInVld_SO  out  1  start pulse to the divider.
- DivOutVld_SI  in  1  divider output valid (also high while the divider is idle).
- DivOutRdy_SO  out  1  result accept to the divider.
- DivRes_DI  in  C_WIDTH  divider result.

Behaviour:
- Reset: FSM=IDLE, RR pointer=0, all registers 0.
- Reset values: ReqGnt_SO=0, RespVld_SO=0, DivInVld_SO=0, DivOutRdy_SO=0, Res_DO=0.
- Operands registered on grant: OpA, OpB, OpCode, ID.
- All Div* outputs are derived combinationally from the registered operands.
- Shift count, unsigned ops (OpCode[0]=0): s = clz(B).
- Shift count, signed ops: s = redundant sign bits of B (leading bits equal to B[MSB], minus 1).
- B == 0 for any op: s = C_WIDTH-1 and DivOpBIsZero_SO=1.
- DivOpB_DO = B << s.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any ReqVld_SI is high, select the first asserted index at or after the RR pointer (wrapping).
  - Pulse ReqGnt_SO[winner] for 1 cycle, latch operands, go to START.
  - No request: stay in IDLE.
- START: DivInVld_SO=1 for exactly 1 cycle, go to WAIT. The divider must be idle here, and this is guaranteed by construction.
- WAIT:
  - DivOutVld_SI is ignored in every state except WAIT.
  - When DivOutVld_SI=1, drive DivOutRdy_SO=1 in the same cycle, register DivRes_DI into Res_DO, go to RESP.
- RESP:
  - RespVld_SO[ID]=1 and Res_DO held stable until RespRdy_SI[ID]=1.
  - On that handshake: go to IDLE and set the RR pointer to (ID+1) mod NUM_REQ.
  - RespRdy_SI of non-owners is ignored.
- Latency: grant in cycle 0 → RespVld in cycle s+4.
- Throughput: one operation in flight; a new grant is possible in the cycle after the response handshake.
- Requests arriving while busy wait: ReqVld must stay high and operands stable until granted.
- Simultaneous requests are resolved by RR only, with no priority override.
- The winner's request is consumed only by ReqGnt_SO; a requester that is re-granted issues a new op.
- Division-by-zero results:
  - udiv and div: all ones.
  - urem and rem: A.
- Overflow (div 0x80000000 / -1): 0x80000000; rem gives 0.
- Reset mid-operation: everything returns to the reset state asynchronously. The divider is reset by the same Rst_RBI, and no stale response is issued.

Test Plan:
- Req0 udiv A=100, B=7 → grant cycle 0; s=29, DivOpB=0xE0000000; RespVld[0] in cycle 33, Res=14; with urem instead, Res=2.
- Req1 div A=-7 (0xFFFFFFF9), B=2 → Res=0xFFFFFFFD (-3); rem gives 0xFFFFFFFF (-1); s=29.
- Req0 and Req1 both held high continuously, pointer=0 → grants alternate 0,1,0,1; each response goes only to the granted ID.
- udiv 5/0 → DivOpBIsZero=1, s=31, Res=0xFFFFFFFF; urem 5/0 → Res=5; div 0x80000000/-1 → Res=0x80000000.
- RespRdy held low for 10 cycles in RESP → RespVld and Res stable; no new grant; a pending request is granted the cycle after the handshake.
- Rst_RBI asserted in WAIT → all outputs 0 immediately; after release an idle request is granted normally with the correct result.
